// File: rtl/red_pitaya_exp_in_if.sv
// System bus between the housekeeping/bus master and the expansion-input block.
// Signals:
//   sys_addr/sys_wdata/sys_sel/sys_wen/sys_ren : request (master -> slave)
//   sys_rdata/sys_err/sys_ack                   : response (slave -> master)
interface red_pitaya_exp_in_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_exp_in.sv
// Expansion connector input conditioner: synchronizes and debounces the raw p/n
// connector pins, records rising/falling edges of the debounced signals in W1C
// sticky registers and raises a level interrupt while any edge is pending.
// Ports:
//   clk_i, rstn_i              : clock, asynchronous active-low reset
//   exp_p_pin_i, exp_n_pin_i   : raw asynchronous connector pins
//   exp_p_dat_o, exp_n_dat_o   : debounced pin states
//   irq_o                      : registered interrupt (IRQ_EN & any sticky bit)
//   sys_bus                    : system bus slave (register map at sys_addr[19:0])
module red_pitaya_exp_in #(
  parameter int unsigned DWE     = 8,
  parameter int unsigned DBW     = 16,
  parameter int unsigned DEB_DEF = 1000
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [DWE-1:0]     exp_p_pin_i,
  input  logic [DWE-1:0]     exp_n_pin_i,
  output logic [DWE-1:0]     exp_p_dat_o,
  output logic [DWE-1:0]     exp_n_dat_o,
  output logic               irq_o,
  red_pitaya_exp_in_if.slave sys_bus
);
  // All per-pin vectors are packed as {n, p}.
  localparam int unsigned NB = 2 * DWE;

  logic [NB-1:0]  meta_q, sync_q;
  logic [NB-1:0]  deb_q, deb_d, deb_dly_q;
  logic [DBW-1:0] cnt_q [NB];
  logic [DBW-1:0] cnt_d [NB];
  logic [DBW-1:0] period_q, period_d;
  logic [NB-1:0]  rise_q, rise_d, fall_q, fall_d;
  logic [NB-1:0]  clr_rise, clr_fall;
  logic           irq_en_q, irq_en_d, irq_q, irq_d;
  logic           ack_q;
  logic [31:0]    rdata_q, rdata_d;

  logic [19:0]    addr;
  logic           wr, rd;
  logic           unused_bus;

  assign addr       = sys_bus.sys_addr[19:0];
  assign wr         = sys_bus.sys_wen;
  assign rd         = sys_bus.sys_ren;
  // Upper address bits and byte selects play no part in decoding.
  assign unused_bus = ^{sys_bus.sys_addr[31:20], sys_bus.sys_sel, sys_bus.sys_wdata};

  // Debounce: count cycles of disagreement; accept the new level once the count
  // has reached the period. Any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= period_q) begin
        deb_d[i] = sync_q[i];
        cnt_d[i] = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  // Sticky edges and control registers. A new edge event overrides a
  // simultaneous W1C of the same bit.
  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    if (wr) begin
      case (addr)
        20'h04:  clr_rise[DWE-1:0]  = sys_bus.sys_wdata[DWE-1:0];
        20'h08:  clr_fall[DWE-1:0]  = sys_bus.sys_wdata[DWE-1:0];
        20'h0C:  clr_rise[NB-1:DWE] = sys_bus.sys_wdata[DWE-1:0];
        20'h10:  clr_fall[NB-1:DWE] = sys_bus.sys_wdata[DWE-1:0];
        default: ;
      endcase
    end
    rise_d   = (rise_q & ~clr_rise) | (deb_q & ~deb_dly_q);
    fall_d   = (fall_q & ~clr_fall) | (~deb_q & deb_dly_q);
    period_d = (wr && addr == 20'h00) ? sys_bus.sys_wdata[DBW-1:0] : period_q;
    irq_en_d = (wr && addr == 20'h14) ? sys_bus.sys_wdata[0] : irq_en_q;
    irq_d    = irq_en_q & (|{rise_q, fall_q});
  end

  // Read data always reflects state before any write in the same cycle.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (addr)
        20'h00:  rdata_d = 32'(period_q);
        20'h04:  rdata_d = 32'(rise_q[DWE-1:0]);
        20'h08:  rdata_d = 32'(fall_q[DWE-1:0]);
        20'h0C:  rdata_d = 32'(rise_q[NB-1:DWE]);
        20'h10:  rdata_d = 32'(fall_q[NB-1:DWE]);
        20'h14:  rdata_d = {31'd0, irq_en_q};
        20'h18:  rdata_d = 32'(sync_q);
        20'h1C:  rdata_d = 32'(deb_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
      period_q  <= DBW'(DEB_DEF);
      rise_q    <= '0;
      fall_q    <= '0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      meta_q    <= {exp_n_pin_i, exp_p_pin_i};
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      period_q  <= period_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      ack_q     <= wr | rd;
      rdata_q   <= rdata_d;
    end
  end

  assign exp_p_dat_o       = deb_q[DWE-1:0];
  assign exp_n_dat_o       = deb_q[NB-1:DWE];
  assign irq_o             = irq_q;
  assign sys_bus.sys_ack   = ack_q;
  assign sys_bus.sys_rdata = rdata_q;
  assign sys_bus.sys_err   = 1'b0;
endmodule

// File: doc/red_pitaya_exp_in.md
RED_PITAYA_EXP_IN -- requirements
Module: red_pitaya_exp_in

Interface
REQ-001 SHALL have parameter DWE, default 8: expansion connector width per polarity (p and n).
REQ-002 SHALL have parameter DBW, default 16: debounce counter width.
REQ-003 SHALL have parameter DEB_DEF, default 16'd1000: reset value of the debounce period.
REQ-004 SHALL have port clk_i, input, 1: clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port exp_p_pin_i, input, DWE: raw asynchronous p-side connector inputs.
REQ-007 SHALL have port exp_n_pin_i, input, DWE: raw asynchronous n-side connector inputs.
REQ-008 SHALL have port exp_p_dat_o, output, DWE: debounced p inputs, feeding the housekeeping exp_p_dat_i.
REQ-009 SHALL have port exp_n_dat_o, output, DWE: debounced n inputs, feeding the housekeeping exp_n_dat_i.
REQ-010 SHALL have port irq_o, output, 1: level interrupt, pending edge events.
REQ-011 SHALL have ports sys_addr (32), sys_wdata (32), sys_sel (4), sys_wen (1) and sys_ren (1), all inputs: system bus slave.
REQ-012 SHALL have ports sys_rdata (32), sys_err (1) and sys_ack (1), all outputs: system bus response.

Function
REQ-013 Each input bit SHALL pass a 2-flop synchronizer; "sync" means the second flop.
REQ-014 Each of the 2*DWE bits SHALL own a DBW-bit counter cnt and a debounced state deb.
- sync==deb: cnt <= 0.
- sync!=deb and cnt>=period: deb <= sync, cnt <= 0.
- otherwise: cnt <= cnt+1, saturating at all-ones.
REQ-015 Latency: deb SHALL follow a stable change exactly period+1 cycles after sync first differs; period 0 gives 1 cycle after sync.
REQ-016 A glitch shorter than period+1 sync cycles SHALL never change deb; a mismatch interruption SHALL restart the count from 0.
REQ-017 exp_p_dat_o/exp_n_dat_o SHALL be the registered deb vectors.
REQ-018 deb 0->1 SHALL set the rise sticky bit and deb 1->0 SHALL set the fall sticky bit of that pin, in the cycle after deb changes.
REQ-019 Registers, decoded on sys_addr[19:0]; reads of undecoded addresses SHALL return 0 and writes to them SHALL be ignored:
- 0x00 PERIOD, RW, [DBW-1:0].
- 0x04 P_RISE, W1C, [DWE-1:0].
- 0x08 P_FALL, W1C.
- 0x0C N_RISE, W1C.
- 0x10 N_FALL, W1C.
- 0x14 IRQ_EN, RW, [0].
- 0x18 RAW, RO: {n_sync, p_sync} in [2*DWE-1:0].
- 0x1C DEB, RO: {n_deb, p_deb}.
REQ-020 A new edge event in the same cycle as a W1C write to its bit SHALL leave the bit set (event wins).
REQ-021 Writing PERIOD SHALL NOT clear any counters; the new value SHALL take effect the next cycle; a running cnt >= new period SHALL update deb on that cycle.
REQ-022 irq_o SHALL be registered: IRQ_EN & OR of all sticky bits, valid one cycle after the sticky change.
REQ-023 sys_ack SHALL equal sys_wen|sys_ren delayed one cycle; sys_rdata SHALL be valid in the ack cycle; sys_err SHALL be always 0; sys_sel SHALL be ignored (full-word access).
REQ-024 Simultaneous sys_wen and sys_ren SHALL perform the write and return read data from pre-write state; one ack.

Reset
REQ-025 While rstn_i=0, the following SHALL hold: synchronizers=0, cnt=0, deb=0, sticky=0, PERIOD=DEB_DEF, IRQ_EN=0, irq_o=0, sys_ack=0, sys_err=0, sys_rdata=0.
REQ-026 Pins held high through reset release SHALL produce rise sticky events after synchronizer + debounce delay.
REQ-027 Reset asserted mid-count SHALL clear state immediately, with no event generated.

Verification
REQ-028 Set PERIOD=3 and raise p pin 0 for 10 cycles: exp_p_dat_o[0] rises 2+4 cycles after the pin, P_RISE=0x01, and irq_o stays 0 (IRQ_EN=0).
REQ-029 Set PERIOD=3 and apply a 3-cycle high pulse on n pin 5: exp_n_dat_o, N_RISE and N_FALL remain 0.
REQ-030 Set IRQ_EN=1 with P_FALL[2] pending, then W1C 0x04 to 0x08: irq_o deasserts 1 cycle after the write ack; reading 0x08 returns 0.
REQ-031 Apply a rise on p pin 1 coincident with a W1C of P_RISE bit 1: reading 0x04 returns 0x02.
REQ-032 Set PERIOD=1000, hold a mismatch for 500 cycles, then write PERIOD=100: deb updates the cycle after the write takes effect.
REQ-033 Read 0x40: sys_rdata=0, sys_ack exactly one cycle after sys_ren, sys_err=0.
